lut_stream_reader: RTL

//  Sequencer that drives the 8-bit LUT block RAM (blk_mem_gen_0) read port and consumes its douta.

---
 rtl/lut_stream_reader_if.sv | 32 +++
 rtl/lut_stream_reader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lut_stream_reader_if.sv
// rtl/lut_stream_reader_if.sv - BRAM read port and sample stream bundle for lut_stream_reader
interface lut_stream_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              bram_ena;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    // Sequencer side: drives the BRAM port and sources the stream
    modport master (
        output bram_ena,
        output bram_addr,
        input  bram_dout,
        output m_data,
        output m_valid,
        input  m_ready
    );

    // BRAM / consumer side
    modport slave (
        input  bram_ena,
        input  bram_addr,
        output bram_dout,
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/lut_stream_reader.sv
// rtl/lut_stream_reader.sv - pipelined BRAM LUT walker with credit-limited output FIFO
module lut_stream_reader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] step,
    input  logic [15:0]       count,
    output logic              busy,
    output logic              done,
    lut_stream_reader_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_step;
    logic [15:0]       r_count;
    logic [15:0]       r_issued;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_last_addr;

    logic [RD_LAT-1:0] r_pipe;
    logic [CNT_W-1:0]  r_inflight;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;

    logic [CNT_W-1:0]  w_outstanding;
    logic              w_credit;
    logic              w_issue;
    logic [15:0]       w_issued_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_nonempty;
    logic              w_drained;
    logic              w_accept;

    // Credit counts every read that could still land in the FIFO, so the FIFO can never overflow
    assign w_outstanding   = r_inflight + CNT_W'(r_occ);
    assign w_credit        = w_outstanding < CNT_W'(FIFO_DEPTH);
    assign w_issue         = (r_state == S_RUN) && !stop && w_credit;
    assign w_issued_nxt    = r_issued + 16'd1;
    assign w_push          = r_pipe[RD_LAT-1];
    assign w_fifo_nonempty = (r_occ != '0);
    assign w_pop           = w_fifo_nonempty && bus.m_ready;
    assign w_drained       = (r_inflight == '0) && !w_fifo_nonempty;
    assign w_accept        = (r_state == S_IDLE) && start && !stop;

    assign bus.bram_ena  = w_issue;
    assign bus.bram_addr = w_issue ? r_addr : r_last_addr;
    assign bus.m_valid   = w_fifo_nonempty;
    assign bus.m_data    = w_fifo_nonempty ? r_mem[r_rd_ptr] : '0;

    // State register
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, busy and the one-cycle done pulse on the final drain cycle
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (stop) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_issue && (r_count != 16'd0) && (w_issued_nxt == r_count)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_drained) begin
                    w_state_nxt = S_IDLE;
                    done        = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Run parameters, address walker and issued-read counter
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_step      <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_addr      <= '0;
            r_last_addr <= '0;
        end else if (w_accept) begin
            r_step   <= step;
            r_count  <= count;
            r_issued <= '0;
            r_addr   <= '0;
        end else if (w_issue) begin
            r_addr      <= r_addr + r_step;
            r_last_addr <= r_addr;
            r_issued    <= w_issued_nxt;
        end
    end

    // Read-valid pipe mirroring the BRAM latency, plus a running count of reads in it
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_pipe     <= '0;
            r_inflight <= '0;
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            if (w_issue && !w_push) begin
                r_inflight <= r_inflight + CNT_W'(1);
            end else if (!w_issue && w_push) begin
                r_inflight <= r_inflight - CNT_W'(1);
            end
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave occupancy unchanged
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    // FIFO storage; contents are only visible through the non-empty gate on m_data
    always_ff @(posedge CLK100MHZ) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.bram_dout;
        end
    end
endmodule
